// File: rtl/friscv_pkg.sv
// Shared types and constants for the friscv memory-port arbiter.
// Requester IDs double as the round-robin last-grant encoding.
package friscv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } arb_state_t;

    typedef logic req_id_t;

    localparam req_id_t REQ_IF = 1'b0;
    localparam req_id_t REQ_D  = 1'b1;

    localparam int unsigned ARB_TIMEOUT = 255;

endpackage

// File: rtl/mem_wait_timer.sv
// 8-bit wait counter for a granted memory access.
// Saturates at limit, so it cannot wrap while the FSM is waiting.
module mem_wait_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       enable,
    input  logic [7:0] limit,
    output logic       expired
);

    logic [7:0] count;

    assign expired = (count == limit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 8'd1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and load/store requesters
// using the mfc handshake, with round-robin ties and a wait timeout.
module mem_port_arbiter
    import friscv_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = ARB_TIMEOUT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_rd,
    input  logic [AW-1:0]   if_addr,
    output logic [DW-1:0]   if_rdata,
    output logic            if_mfc,
    output logic            if_err,
    input  logic            d_rd,
    input  logic            d_wr,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    input  logic [DW/8-1:0] d_be,
    output logic [DW-1:0]   d_rdata,
    output logic            d_mfc,
    output logic            d_err,
    output logic            m_rd,
    output logic            m_wr,
    output logic [AW-1:0]   m_addr,
    output logic [DW-1:0]   m_wdata,
    output logic [DW/8-1:0] m_be,
    input  logic [DW-1:0]   m_rdata,
    input  logic            m_mfc
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

    arb_state_t state;
    req_id_t    owner;
    req_id_t    last_grant;
    req_id_t    pick;
    logic       if_req;
    logic       d_req;
    logic       expired;
    logic [DW-1:0] rd_val;

    assign if_req = if_rd;
    assign d_req  = d_rd | d_wr;
    assign rd_val = m_mfc ? m_rdata : '0;

    // On a tie the requester not served last goes next.
    always_comb begin
        pick = REQ_IF;
        if (if_req && d_req) begin
            pick = (last_grant == REQ_IF) ? REQ_D : REQ_IF;
        end else if (d_req) begin
            pick = REQ_D;
        end
    end

    mem_wait_timer u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (state != WAIT),
        .enable  (state == WAIT),
        .limit   (LIMIT),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= REQ_IF;
            last_grant <= REQ_D;
            m_rd       <= 1'b0;
            m_wr       <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
            m_be       <= '0;
            if_rdata   <= '0;
            if_mfc     <= 1'b0;
            if_err     <= 1'b0;
            d_rdata    <= '0;
            d_mfc      <= 1'b0;
            d_err      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (if_req || d_req) begin
                        owner <= pick;
                        state <= WAIT;
                        if (pick == REQ_IF) begin
                            m_rd    <= 1'b1;
                            m_wr    <= 1'b0;
                            m_addr  <= if_addr;
                            m_wdata <= '0;
                            m_be    <= '1;
                        end else begin
                            m_rd    <= ~d_wr;
                            m_wr    <= d_wr;
                            m_addr  <= d_addr;
                            m_wdata <= d_wdata;
                            m_be    <= d_be;
                        end
                    end
                end
                // m_mfc takes priority over a same-cycle timeout.
                WAIT: begin
                    if (m_mfc || expired) begin
                        m_rd  <= 1'b0;
                        m_wr  <= 1'b0;
                        state <= DONE;
                        if (owner == REQ_IF) begin
                            if_mfc   <= 1'b1;
                            if_err   <= ~m_mfc;
                            if_rdata <= rd_val;
                        end else begin
                            d_mfc   <= 1'b1;
                            d_err   <= ~m_mfc;
                            d_rdata <= rd_val;
                        end
                    end
                end
                DONE: begin
                    if_mfc     <= 1'b0;
                    if_err     <= 1'b0;
                    d_mfc      <= 1'b0;
                    d_err      <= 1'b0;
                    last_grant <= owner;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
// Memory responses are driven by hand; expected values are constants.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk;
    logic            rst_n;
    logic            if_rd;
    logic [AW-1:0]   if_addr;
    logic [DW-1:0]   if_rdata;
    logic            if_mfc;
    logic            if_err;
    logic            d_rd;
    logic            d_wr;
    logic [AW-1:0]   d_addr;
    logic [DW-1:0]   d_wdata;
    logic [DW/8-1:0] d_be;
    logic [DW-1:0]   d_rdata;
    logic            d_mfc;
    logic            d_err;
    logic            m_rd;
    logic            m_wr;
    logic [AW-1:0]   m_addr;
    logic [DW-1:0]   m_wdata;
    logic [DW/8-1:0] m_be;
    logic [DW-1:0]   m_rdata;
    logic            m_mfc;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(
        .AW      (AW),
        .DW      (DW),
        .TIMEOUT (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .if_rd    (if_rd),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_mfc   (if_mfc),
        .if_err   (if_err),
        .d_rd     (d_rd),
        .d_wr     (d_wr),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_be     (d_be),
        .d_rdata  (d_rdata),
        .d_mfc    (d_mfc),
        .d_err    (d_err),
        .m_rd     (m_rd),
        .m_wr     (m_wr),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_be     (m_be),
        .m_rdata  (m_rdata),
        .m_mfc    (m_mfc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic fetch_access(input logic [31:0] a,
                                input logic [31:0] dat);
        if_rd   = 1'b1;
        if_addr = a;
        tick();
        chk("f_mrd", 64'(m_rd), 64'd1);
        chk("f_maddr", 64'(m_addr), 64'(a));
        chk("f_mbe", 64'(m_be), 64'hF);
        m_mfc   = 1'b1;
        m_rdata = dat;
        tick();
        m_mfc = 1'b0;
        chk("f_mfc", 64'(if_mfc), 64'd1);
        chk("f_rdata", 64'(if_rdata), 64'(dat));
        chk("f_err", 64'(if_err), 64'd0);
        chk("f_mrd_off", 64'(m_rd), 64'd0);
        if_rd = 1'b0;
        tick();
        chk("f_mfc_off", 64'(if_mfc), 64'd0);
    endtask

    initial begin
        int rd_cycles;
        rst_n   = 1'b0;
        if_rd   = 1'b0;
        if_addr = '0;
        d_rd    = 1'b0;
        d_wr    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
        d_be    = '0;
        m_rdata = '0;
        m_mfc   = 1'b0;
        tick();
        tick();
        chk("rst_mrd", 64'(m_rd), 64'd0);
        chk("rst_mwr", 64'(m_wr), 64'd0);
        chk("rst_maddr", 64'(m_addr), 64'd0);
        chk("rst_mbe", 64'(m_be), 64'd0);
        chk("rst_ifmfc", 64'(if_mfc), 64'd0);
        chk("rst_dmfc", 64'(d_mfc), 64'd0);
        chk("rst_drdata", 64'(d_rdata), 64'd0);
        rst_n = 1'b1;
        tick();

        // fetch only
        fetch_access(32'h100, 32'h0050_0093);

        // tie after reset: fetch first, then a second tie goes to data
        rst_n = 1'b0;
        tick();
        rst_n   = 1'b1;
        if_rd   = 1'b1;
        if_addr = 32'h104;
        d_wr    = 1'b1;
        d_addr  = 32'h2000;
        d_wdata = 32'hDEAD_BEEF;
        d_be    = 4'h3;
        tick();
        chk("tie1_mrd", 64'(m_rd), 64'd1);
        chk("tie1_mwr", 64'(m_wr), 64'd0);
        chk("tie1_addr", 64'(m_addr), 64'h104);
        chk("tie1_be", 64'(m_be), 64'hF);
        m_mfc   = 1'b1;
        m_rdata = 32'h0000_0013;
        tick();
        m_mfc = 1'b0;
        chk("tie1_ifmfc", 64'(if_mfc), 64'd1);
        chk("tie1_dmfc", 64'(d_mfc), 64'd0);
        chk("tie1_rdata", 64'(if_rdata), 64'h13);
        if_rd = 1'b0;
        tick();
        if_rd   = 1'b1;
        if_addr = 32'h108;
        tick();
        chk("tie2_mwr", 64'(m_wr), 64'd1);
        chk("tie2_mrd", 64'(m_rd), 64'd0);
        chk("tie2_addr", 64'(m_addr), 64'h2000);
        chk("tie2_wdata", 64'(m_wdata), 64'hDEAD_BEEF);
        chk("tie2_be", 64'(m_be), 64'h3);
        m_mfc = 1'b1;
        tick();
        m_mfc = 1'b0;
        chk("tie2_dmfc", 64'(d_mfc), 64'd1);
        chk("tie2_derr", 64'(d_err), 64'd0);
        chk("tie2_ifmfc", 64'(if_mfc), 64'd0);
        d_wr = 1'b0;
        tick();
        tick();
        chk("tie3_mrd", 64'(m_rd), 64'd1);
        chk("tie3_addr", 64'(m_addr), 64'h108);
        m_mfc   = 1'b1;
        m_rdata = 32'h0000_0113;
        tick();
        m_mfc = 1'b0;
        chk("tie3_ifmfc", 64'(if_mfc), 64'd1);
        chk("tie3_rdata", 64'(if_rdata), 64'h113);
        if_rd = 1'b0;
        tick();

        // five wait states
        d_rd   = 1'b1;
        d_addr = 32'h3000;
        tick();
        rd_cycles = 0;
        for (int i = 0; i < 6; i++) begin
            if (m_rd === 1'b1 && m_addr === 32'h3000) rd_cycles++;
            if (i == 5) begin
                m_mfc   = 1'b1;
                m_rdata = 32'hCAFE_F00D;
            end
            tick();
        end
        m_mfc = 1'b0;
        chk("ws_rd_cycles", 64'(rd_cycles), 64'd6);
        chk("ws_dmfc", 64'(d_mfc), 64'd1);
        chk("ws_rdata", 64'(d_rdata), 64'hCAFE_F00D);
        chk("ws_mrd_off", 64'(m_rd), 64'd0);
        d_rd = 1'b0;
        tick();
        chk("ws_dmfc_off", 64'(d_mfc), 64'd0);

        // timeout with no m_mfc
        d_rd    = 1'b1;
        d_addr  = 32'h4000;
        m_rdata = 32'h1111_1111;
        tick();
        rd_cycles = 0;
        for (int i = 0; i < 8; i++) begin
            if (m_rd === 1'b1) rd_cycles++;
            tick();
        end
        chk("to_rd_cycles", 64'(rd_cycles), 64'd8);
        chk("to_dmfc", 64'(d_mfc), 64'd1);
        chk("to_derr", 64'(d_err), 64'd1);
        chk("to_rdata", 64'(d_rdata), 64'd0);
        chk("to_mrd_off", 64'(m_rd), 64'd0);
        d_rd = 1'b0;
        tick();
        chk("to_derr_off", 64'(d_err), 64'd0);

        // m_mfc collides with the timeout cycle
        d_rd = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            if (i == 7) begin
                m_mfc   = 1'b1;
                m_rdata = 32'h2222_2222;
            end
            tick();
        end
        m_mfc = 1'b0;
        chk("col_dmfc", 64'(d_mfc), 64'd1);
        chk("col_derr", 64'(d_err), 64'd0);
        chk("col_rdata", 64'(d_rdata), 64'h2222_2222);
        d_rd = 1'b0;
        tick();

        // fetch served last, then reset in WAIT restores fetch priority
        fetch_access(32'h200, 32'h0000_0001);
        d_rd   = 1'b1;
        d_addr = 32'h5000;
        tick();
        chk("rw_mrd", 64'(m_rd), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rw_mrd_async", 64'(m_rd), 64'd0);
        chk("rw_maddr", 64'(m_addr), 64'd0);
        @(posedge clk);
        #1;
        chk("rw_dmfc", 64'(d_mfc), 64'd0);
        rst_n   = 1'b1;
        if_rd   = 1'b1;
        if_addr = 32'h10C;
        d_wr    = 1'b1;
        d_wdata = 32'h1234_5678;
        d_be    = 4'hF;
        tick();
        chk("rw_tie_mrd", 64'(m_rd), 64'd1);
        chk("rw_tie_addr", 64'(m_addr), 64'h10C);
        chk("rw_tie_dmfc", 64'(d_mfc), 64'd0);
        m_mfc   = 1'b1;
        m_rdata = 32'h0000_0223;
        tick();
        m_mfc = 1'b0;
        chk("rw_ifmfc", 64'(if_mfc), 64'd1);
        if_rd = 1'b0;
        tick();

        // d_rd and d_wr together perform a write
        tick();
        chk("rdwr_mwr", 64'(m_wr), 64'd1);
        chk("rdwr_mrd", 64'(m_rd), 64'd0);
        chk("rdwr_addr", 64'(m_addr), 64'h5000);
        chk("rdwr_wdata", 64'(m_wdata), 64'h1234_5678);
        m_mfc = 1'b1;
        tick();
        m_mfc = 1'b0;
        chk("rdwr_dmfc", 64'(d_mfc), 64'd1);
        chk("rdwr_mwr_off", 64'(m_wr), 64'd0);
        d_rd = 1'b0;
        d_wr = 1'b0;
        tick();
        chk("rdwr_dmfc_off", 64'(d_mfc), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
